// File: rtl/hdc_class_pkg.sv
// hdc_class_pkg: shared sizes, frame type and loader FSM states for the class-hypervector store.
package hdc_class_pkg;
  localparam int HV_FRAME_W       = 64;
  localparam int NUM_CLASSES      = 8;
  localparam int FRAMES_PER_CLASS = 3;
  localparam int CLASS_ID_W       = 3;
  localparam int FRAME_IDX_W      = 2;
  typedef logic [HV_FRAME_W-1:0] frame_t;
  typedef enum logic [1:0] {IDLE, CLEAR, LOAD, DONE} state_t;
endpackage

// File: rtl/class_hvec_slot_mem.sv
// class_hvec_slot_mem: flop array of class frames, one sync write port, bulk clear, comb read.
module class_hvec_slot_mem
  import hdc_class_pkg::*;
(
  input  logic                   clk,
  input  logic                   clr_i,
  input  logic                   we_i,
  input  logic [CLASS_ID_W-1:0]  wcls_i,
  input  logic [FRAME_IDX_W-1:0] wfrm_i,
  input  logic [HV_FRAME_W-1:0]  wdata_i,
  input  logic [CLASS_ID_W-1:0]  rcls_i,
  input  logic [FRAME_IDX_W-1:0] rfrm_i,
  output logic [HV_FRAME_W-1:0]  rdata_o
);
  frame_t mem_q [NUM_CLASSES][FRAMES_PER_CLASS];
  always_ff @(posedge clk) begin
    if (clr_i) begin
      for (int c = 0; c < NUM_CLASSES; c++)
        for (int f = 0; f < FRAMES_PER_CLASS; f++)
          mem_q[c][f] <= '0;
    end else if (we_i) begin
      mem_q[wcls_i][wfrm_i] <= wdata_i;
    end
  end
  // Unpopulated id/index combinations read as zero rather than aliasing a real slot.
  assign rdata_o = (int'(rcls_i) < NUM_CLASSES && int'(rfrm_i) < FRAMES_PER_CLASS)
                   ? mem_q[rcls_i][rfrm_i] : '0;
endmodule

// File: rtl/class_hvec_loader.sv
// class_hvec_loader: loads class hypervector frames from a valid/ready stream into the slot store.
// Define CLASS_HVEC_CLEAR_EN to zero every slot in a CLEAR pass before each load.
module class_hvec_loader
  import hdc_class_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [HV_FRAME_W-1:0]  in_data,
  output logic                   busy,
  output logic                   done,
  input  logic [CLASS_ID_W-1:0]  frame_id,
  input  logic [FRAME_IDX_W-1:0] frame_index,
  output logic [HV_FRAME_W-1:0]  class_vec_out
);
`ifdef CLASS_HVEC_CLEAR_EN
  localparam state_t FIRST = CLEAR;
`else
  localparam state_t FIRST = LOAD;
`endif
  state_t state_q, state_d;
  logic [CLASS_ID_W-1:0] cls_q, cls_d, cls_nx;
  logic [FRAME_IDX_W-1:0] frm_q, frm_d, frm_nx;
  logic last_frm, last_slot, we;
  frame_t wdata;
  assign last_frm  = frm_q == FRAME_IDX_W'(FRAMES_PER_CLASS - 1);
  assign last_slot = last_frm && cls_q == CLASS_ID_W'(NUM_CLASSES - 1);
  assign frm_nx    = last_frm ? '0 : frm_q + 1'b1;
  assign cls_nx    = last_slot ? '0 : last_frm ? cls_q + 1'b1 : cls_q;
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    frm_d   = frm_q;
    we      = 1'b0;
    wdata   = in_data;
    case (state_q)
      IDLE: if (start && !abort) begin
        state_d = FIRST;
        cls_d   = '0;
        frm_d   = '0;
      end
      CLEAR: if (abort) state_d = IDLE;
      else begin
        we      = 1'b1;
        wdata   = '0;
        cls_d   = cls_nx;
        frm_d   = frm_nx;
        state_d = last_slot ? LOAD : CLEAR;
      end
      LOAD: if (abort) state_d = IDLE;
      else if (in_valid) begin
        we      = 1'b1;
        cls_d   = cls_nx;
        frm_d   = frm_nx;
        state_d = last_slot ? DONE : LOAD;
      end
      DONE: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cls_q   <= '0;
      frm_q   <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      frm_q   <= frm_d;
    end
  end
  assign in_ready = state_q == LOAD;
  assign busy     = state_q == CLEAR || state_q == LOAD;
  assign done     = state_q == DONE;
  class_hvec_slot_mem u_mem (
    .clk     (clk),
    .clr_i   (!rst_n),
    .we_i    (we),
    .wcls_i  (cls_q),
    .wfrm_i  (frm_q),
    .wdata_i (wdata),
    .rcls_i  (frame_id),
    .rfrm_i  (frame_index),
    .rdata_o (class_vec_out)
  );
endmodule

// File: tb/tb_class_hvec_loader.sv
// tb_class_hvec_loader: randomized directed bench for class_hvec_loader against a flat slot model.
// Honours CLASS_HVEC_CLEAR_EN the same way the design does.
module tb_class_hvec_loader;
  logic clk = 0, rst_n = 0, start = 0, abort = 0, in_valid = 0;
  logic in_ready, busy, done;
  logic [63:0] in_data = '0, class_vec_out;
  logic [2:0] frame_id = '0;
  logic [1:0] frame_index = '0;
  int total = 0, bad = 0, n = 0;
  logic [63:0] exp_mem [24];

  always #5 clk = ~clk;

  class_hvec_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .busy(busy), .done(done), .frame_id(frame_id), .frame_index(frame_index),
    .class_vec_out(class_vec_out)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] mref(input int id, input int idx);
    return (id < 8 && idx < 3) ? exp_mem[id*3 + idx] : 64'h0;
  endfunction

  function automatic logic [63:0] pat(input int k);
    return 64'hC0DE_0000_0000_0000 | 64'(((k / 3) << 4) | (k % 3));
  endfunction

  task automatic model_clear;
    foreach (exp_mem[i]) exp_mem[i] = '0;
  endtask

  task automatic readback(input string tag);
    for (int id = 0; id < 8; id++)
      for (int idx = 0; idx < 4; idx++) begin
        frame_id = 3'(id);
        frame_index = 2'(idx);
        #1;
        chk($sformatf("%s[%0d][%0d]", tag, id, idx), class_vec_out, mref(id, idx));
      end
  endtask

  task automatic pulse_start;
`ifdef CLASS_HVEC_CLEAR_EN
    int cnt;
`endif
    start = 1;
    tick;
    start = 0;
    n = 0;
`ifdef CLASS_HVEC_CLEAR_EN
    model_clear;
    cnt = 0;
    chk("clr_busy", 64'(busy), 64'd1);
    while (!in_ready && cnt < 40) begin
      cnt++;
      tick;
    end
    chk("clr_cycles", 64'(cnt), 64'd24);
`else
    chk("ready_after_start", 64'(in_ready), 64'd1);
    chk("busy_after_start", 64'(busy), 64'd1);
`endif
  endtask

  // Offers one frame after `gaps` idle cycles; the model records it only on an observed handshake.
  task automatic send(input logic [63:0] d, input int gaps);
    logic ok;
    ok = 0;
    repeat (gaps) begin
      in_valid = 0;
      in_data = 64'($urandom);
      tick;
    end
    in_valid = 1;
    in_data = d;
    frame_id = 3'(n / 3);
    frame_index = 2'(n % 3);
    #1;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (in_ready) begin
        chk("rd_old", class_vec_out, mref(n / 3, n % 3));
        ok = 1;
      end
      tick;
    end
    in_valid = 0;
    if (!ok) chk("hs_timeout", 64'(ok), 64'd1);
    else begin
      exp_mem[n] = d;
      n++;
      chk("rd_new", class_vec_out, d);
      chk("done", 64'(done), 64'(n == 24));
    end
  endtask

  initial begin
    logic [63:0] d0;
    model_clear;
    tick;
    tick;
    rst_n = 1;
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    readback("rst_rd");

    pulse_start;
    for (int k = 0; k < 24; k++) send(pat(k), 0);
    tick;
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    readback("pat_rd");

    d0 = {$urandom, $urandom};
    in_valid = 1;
    in_data = d0;
    for (int k = 0; k < 5; k++) begin
      tick;
      chk("stall_ready", 64'(in_ready), 64'd0);
    end
    pulse_start;
    send(d0, 0);
    for (int k = 1; k < 24; k++) send({$urandom, $urandom}, int'($urandom_range(0, 3)));
    tick;
    readback("rand_rd");

    pulse_start;
    for (int k = 0; k < 7; k++) send({$urandom, $urandom}, int'($urandom_range(0, 2)));
    abort = 1;
    in_valid = 1;
    in_data = {$urandom, $urandom};
    tick;
    abort = 0;
    in_valid = 0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_ready", 64'(in_ready), 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("abort_no_done", 64'(done), 64'd0);
    end
    readback("abort_rd");

    pulse_start;
    send({$urandom, $urandom}, 0);
    send({$urandom, $urandom}, 1);
    start = 1;
    tick;
    start = 0;
    chk("start_busy_ignored", 64'(busy), 64'd1);
    send({$urandom, $urandom}, 0);
    start = 1;
    abort = 1;
    tick;
    start = 0;
    abort = 0;
    chk("start_abort_load", 64'(busy), 64'd0);
    start = 1;
    abort = 1;
    tick;
    start = 0;
    abort = 0;
    chk("start_abort_idle", 64'(busy), 64'd0);
    readback("sa_rd");

    pulse_start;
    for (int k = 0; k < 24; k++) send('1, 0);
    tick;
    pulse_start;
    readback("reload_rd");
    abort = 1;
    tick;
    abort = 0;

    pulse_start;
    for (int k = 0; k < 3; k++) send({$urandom, $urandom}, 0);
    rst_n = 0;
    tick;
    rst_n = 1;
    model_clear;
    n = 0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_ready", 64'(in_ready), 64'd0);
    readback("midrst_rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
